// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and request legality check for mem_access_unit
// Purpose : access-size encodings, FSM state enum and the misalignment/illegal
//           request check shared by mem_access_unit and subword_align.
// Ports   : none (package).
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_W,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

  // Only meaningful for memory ops; a pure ALU pass-through never faults.
  function automatic logic is_illegal(input logic [1:0] size,
                                      input logic [1:0] lo,
                                      input logic       rd,
                                      input logic       wr);
    logic bad;
    bad = (rd && wr)
       || (size == SZ_ILL)
       || ((size == SZ_HALF) && lo[0])
       || ((size == SZ_WORD) && (lo != 2'b00));
    return bad;
  endfunction

endpackage

// File: rtl/subword_align.sv
// rtl/subword_align.sv - combinational load lane extract/extend and store lane merge
// Purpose : little-endian sub-word handling on a 32-bit memory word.
// Ports   : word_i   memory word (ReadData)
//           lane_i   byte offset a[1:0]
//           size_i   access size encoding
//           signed_i 1 = sign-extend loaded byte/half
//           store_i  store source (data in low bits)
//           load_o   extracted and extended load value
//           merge_o  word_i with the addressed lane(s) replaced by store_i
module subword_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign sh      = {lane_i, 3'b000};
  assign shifted = word_i >> sh;

  always_comb begin
    load_o = word_i;
    mask   = 32'hFFFF_FFFF;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_FFFF << sh;
      end
      default: begin
        load_o = word_i;
        mask   = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Excess high bits of store_i fall outside the mask and are dropped.
  assign merge_o = (word_i & ~mask) | ((store_i << sh) & mask);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store requester with sub-word RMW and load extension
// Purpose : accepts one EX/MEM request at a time, drives the word-only data
//           memory, performs read-modify-write for byte/half stores, extends
//           loads and delivers a one-cycle MEM/WB result pulse.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, ALUResult, StoreData, MemReadEx, MemWriteEx,
//           MemSize, MemSigned, RdIn, RegWriteIn       (from EX/MEM)
//           Address, WriteData, MemWrite, MemRead, ReadData (data memory)
//           wb_valid, wb_data, wb_rd, wb_regwrite, misalign_exc (to MEM/WB)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemReadEx,
  input  logic              MemWriteEx,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [4:0]        RdIn,
  input  logic              RegWriteIn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic              misalign_exc
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              regwrite_q, regwrite_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              exc_q, exc_d;

  logic              mem_op;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign mem_op = MemReadEx | MemWriteEx;

  subword_align u_align (
    .word_i   (ReadData),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .store_i  (sdata_q),
    .load_o   (load_ext),
    .merge_o  (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      sdata_q       <= '0;
      size_q        <= SZ_BYTE;
      signed_q      <= 1'b0;
      regwrite_q    <= 1'b0;
      wdata_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      exc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      sdata_q       <= sdata_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      regwrite_q    <= regwrite_d;
      wdata_q       <= wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      exc_q         <= exc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sdata_d       = sdata_q;
    size_d        = size_q;
    signed_d      = signed_q;
    regwrite_d    = regwrite_q;
    wdata_d       = wdata_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    exc_d         = 1'b0;
    in_ready      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    WriteData     = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d     = ALUResult;
          sdata_d    = StoreData;
          size_d     = MemSize;
          signed_d   = MemSigned;
          regwrite_d = RegWriteIn;
          wb_rd_d    = RdIn;
          if (!mem_op) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = DATA_W'(ALUResult);
            wb_regwrite_d = RegWriteIn;
          end else if (is_illegal(MemSize, ALUResult[1:0], MemReadEx, MemWriteEx)) begin
            wb_valid_d = 1'b1;
            wb_data_d  = DATA_W'(ALUResult);
            exc_d      = 1'b1;
          end else if (MemReadEx) begin
            state_d = ST_LOAD;
          end else if (MemSize == SZ_WORD) begin
            // Store results are reported during the write cycle itself.
            state_d    = ST_STORE_W;
            wdata_d    = StoreData;
            wb_valid_d = 1'b1;
            wb_data_d  = DATA_W'(ALUResult);
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        MemRead       = 1'b1;
        wb_valid_d    = 1'b1;
        wb_data_d     = load_ext;
        wb_regwrite_d = regwrite_q;
        state_d       = ST_IDLE;
      end
      ST_STORE_W: begin
        MemWrite  = 1'b1;
        WriteData = wdata_q;
        state_d   = ST_IDLE;
      end
      ST_RMW_RD: begin
        // Merge against the live read so RMW_WR only replays a register.
        MemRead    = 1'b1;
        wdata_d    = merged;
        wb_valid_d = 1'b1;
        wb_data_d  = DATA_W'(addr_q);
        state_d    = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        MemWrite  = 1'b1;
        WriteData = wdata_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Address      = {addr_q[ADDR_W-1:2], 2'b00};
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign misalign_exc = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural data memory
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ALUResult = '0;
  logic [31:0] StoreData = '0;
  logic        MemReadEx = 1'b0;
  logic        MemWriteEx = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic        MemSigned = 1'b0;
  logic [4:0]  RdIn = '0;
  logic        RegWriteIn = 1'b0;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        misalign_exc;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .MemReadEx(MemReadEx),
    .MemWriteEx(MemWriteEx), .MemSize(MemSize), .MemSigned(MemSigned),
    .RdIn(RdIn), .RegWriteIn(RegWriteIn), .Address(Address),
    .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .misalign_exc(misalign_exc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Behavioural data memory: combinational read, write at the clock edge.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          cyc = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] last_ra = '0;

  assign ReadData = mem[Address[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (MemWrite) begin
      mem[Address[5:2]] <= WriteData;
      last_wa <= Address;
      last_wd <= WriteData;
    end
    if (MemWrite) wr_cnt <= wr_cnt + 1;
    if (MemRead) begin
      rd_cnt  <= rd_cnt + 1;
      last_ra <= Address;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && (MemRead || MemWrite)) chk("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
    if (rst_n && !wb_valid && misalign_exc) chk("exc_without_wb", 32'd1, 32'd0);
    if (rst_n && wb_valid) begin
      if (sbq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, mon_e.rd});
        chk("wb_regwrite", {31'b0, wb_regwrite}, {31'b0, mon_e.rw});
        chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, mon_e.exc});
        chk("wb_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [31:0] w, input int lane,
                                           input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = w[8*lane +: 16];
    case (sz)
      2'b00:   return sgn && b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
      2'b01:   return sgn && h[15] ? {16'hFFFF, h}   : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w, input int lane,
                                           input logic [1:0] sz, input logic [31:0] sd);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[8*lane +: 8]  = sd[7:0];
      2'b01:   r[8*lane +: 16] = sd[15:0];
      default: r = sd;
    endcase
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    poke_en  = 1'b1;
    poke_idx = idx[3:0];
    poke_val = v;
    ref_mem[idx] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the unit is idle again.
  task automatic issue(input logic rd_i, input logic wr_i, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rdreg, input logic rw,
                       input logic [31:0] exp_data, input logic chk_d,
                       input logic exc, input int lat,
                       output int busy, output int drd, output int dwr);
    exp_t e;
    int   n;
    int   rd0;
    int   wr0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    in_valid   = 1'b1;
    MemReadEx  = rd_i;
    MemWriteEx = wr_i;
    MemSize    = sz;
    MemSigned  = sgn;
    ALUResult  = a;
    StoreData  = sd;
    RdIn       = rdreg;
    RegWriteIn = rw;
    e.data     = exp_data;
    e.chk_data = chk_d;
    e.rd       = rdreg;
    e.rw       = (exc || wr_i) ? 1'b0 : rw;
    e.exc      = exc;
    e.cyc      = cyc + lat;
    sbq.push_back(e);
    @(negedge clk);
    in_valid   = 1'b0;
    MemReadEx  = 1'b0;
    MemWriteEx = 1'b0;
    busy = 0;
    while (!in_ready && busy < 20) begin @(negedge clk); busy++; end
    if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int drd;
    int dwr;
    int wr0;
    int lane;
    int idx;
    logic [1:0]  sz;
    logic        st;
    logic        sgn;
    logic [31:0] sd;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word load
    poke(1, 32'hDEADBEEF);
    issue(1, 0, 2'b10, 0, 32'h4, 0, 5'd1, 1, 32'hDEADBEEF, 1, 0, 2, busy, drd, dwr);
    chk("lw_reads", drd, 1);
    chk("lw_writes", dwr, 0);
    chk("lw_addr", last_ra, 32'h4);
    chk("lw_busy", busy, 1);

    // Signed / unsigned byte loads at lane 3, back-to-back with an ALU op
    poke(1, 32'h80112233);
    issue(1, 0, 2'b00, 1, 32'h7, 0, 5'd2, 1, 32'hFFFFFF80, 1, 0, 2, busy, drd, dwr);
    issue(1, 0, 2'b00, 0, 32'h7, 0, 5'd3, 1, 32'h00000080, 1, 0, 2, busy, drd, dwr);
    issue(0, 0, 2'b11, 0, 32'h12345677, 0, 5'd4, 1, 32'h12345677, 1, 0, 1, busy, drd, dwr);
    chk("alu_strobes", drd + dwr, 0);
    chk("alu_busy", busy, 0);

    // Halfword store via read-modify-write
    poke(1, 32'h11223344);
    issue(0, 1, 2'b01, 0, 32'h6, 32'h0000ABCD, 5'd5, 1, 0, 0, 0, 2, busy, drd, dwr);
    chk("sh_busy", busy, 2);
    chk("sh_reads", drd, 1);
    chk("sh_writes", dwr, 1);
    chk("sh_wdata", last_wd, 32'hABCD3344);
    chk("sh_waddr", last_wa, 32'h4);
    chk("sh_mem", mem[1], 32'hABCD3344);
    issue(1, 0, 2'b01, 1, 32'h6, 0, 5'd6, 1, 32'hFFFFABCD, 1, 0, 2, busy, drd, dwr);
    issue(1, 0, 2'b01, 0, 32'h4, 0, 5'd7, 1, 32'h00003344, 1, 0, 2, busy, drd, dwr);

    // Word store, then byte store into the same word
    issue(0, 1, 2'b10, 0, 32'h8, 32'h12345678, 5'd8, 1, 0, 0, 0, 1, busy, drd, dwr);
    chk("sw_writes", dwr, 1);
    chk("sw_reads", drd, 0);
    chk("sw_wdata", last_wd, 32'h12345678);
    chk("sw_waddr", last_wa, 32'h8);
    issue(0, 1, 2'b00, 0, 32'h9, 32'hFFFFFF5A, 5'd9, 1, 0, 0, 0, 2, busy, drd, dwr);
    chk("sb_mem", mem[2], 32'h12345A78);

    // Illegal requests: no strobes, exception pulse, no writeback
    issue(1, 0, 2'b10, 0, 32'h6, 0, 5'd10, 1, 0, 0, 1, 1, busy, drd, dwr);
    chk("lw_mis_strobes", drd + dwr, 0);
    issue(0, 1, 2'b01, 0, 32'h1, 32'h55, 5'd11, 1, 0, 0, 1, 1, busy, drd, dwr);
    chk("sh_mis_strobes", drd + dwr, 0);
    issue(1, 0, 2'b11, 0, 32'h0, 0, 5'd12, 1, 0, 0, 1, 1, busy, drd, dwr);
    issue(1, 1, 2'b10, 0, 32'h8, 32'h1, 5'd13, 1, 0, 0, 1, 1, busy, drd, dwr);
    chk("both_strobes", drd + dwr, 0);
    chk("both_mem", mem[2], 32'h12345A78);

    // Reset while the RMW is in its read phase
    poke(0, 32'hA5A5A5A5);
    wr0 = wr_cnt;
    in_valid = 1'b1; MemWriteEx = 1'b1; MemReadEx = 1'b0; MemSize = 2'b00;
    ALUResult = 32'h2; StoreData = 32'h77; RdIn = 5'd14; RegWriteIn = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; MemWriteEx = 1'b0;
    chk("rmw_rd_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_memwrite", {31'b0, MemWrite}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_writes", wr_cnt - wr0, 0);
    chk("rst_mid_mem", mem[0], 32'hA5A5A5A5);

    // Random loads/stores against the reference memory
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    for (int k = 0; k < 30; k++) begin
      sz  = 2'($urandom_range(0, 2));
      idx = $urandom_range(0, 15);
      lane = (sz == 2'b00) ? $urandom_range(0, 3) : (sz == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
      a   = 32'(idx * 4 + lane);
      st  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sd  = $urandom;
      if (st) begin
        issue(0, 1, sz, sgn, a, sd, 5'($urandom_range(1, 31)), 1, 0, 0, 0,
              (sz == 2'b10) ? 1 : 2, busy, drd, dwr);
        ref_mem[idx] = st_model(ref_mem[idx], lane, sz, sd);
      end else begin
        issue(1, 0, sz, sgn, a, 0, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
              ld_model(ref_mem[idx], lane, sz, sgn), 1, 0, 2, busy, drd, dwr);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("rand_mem", mem[i], ref_mem[i]);
    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
